// File: rtl/bridge_timer_pkg.sv
// bridge_timer_pkg: shared FSM state, register map and byte-merge helper
// for the memory-mapped bridge timer.
package bridge_timer_pkg;
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;
   localparam logic [1:0] OFF_CTRL = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT = 2'd2;
   localparam int CTRL_EN = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IM = 3;
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD = 2'b01;
   function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/bridge_timer.sv
// bridge_timer: programmable down-counter on the CPU IO bridge with
// one-cycle registered read data and a maskable sticky interrupt.
module bridge_timer
   import bridge_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IOWrite,
   input  logic [29:0] PrAddr,
   input  logic [31:0] PrWD,
   input  logic [3:0]  PrBE,
   output logic [31:0] PrRD,
   output logic        hit_q,
   output logic        irq
);
   state_t      r_state, w_state_nxt;
   logic [3:0]  r_ctrl, w_ctrl_nxt;
   logic [31:0] r_preset, r_count, w_count_nxt, w_rd;
   logic        r_pend, w_hit, w_wr_ctrl, w_wr_pre, w_clr_en, w_set_pend, w_en, w_reload;
   logic [1:0]  w_off;

   assign w_hit = PrAddr[29:2] == BASE_ADDR[31:4];
   assign w_off = PrAddr[1:0];
   assign w_wr_ctrl = IOWrite && w_hit && w_off == OFF_CTRL;
   assign w_wr_pre = IOWrite && w_hit && w_off == OFF_PRESET;
   assign w_en = r_ctrl[CTRL_EN];
   assign w_reload = r_ctrl[CTRL_MODE +: 2] == MODE_RELOAD;
   assign irq = r_pend & r_ctrl[CTRL_IM];
   assign w_rd = w_off == OFF_CTRL   ? {28'd0, r_ctrl} :
                 w_off == OFF_PRESET ? r_preset :
                 w_off == OFF_COUNT  ? r_count : 32'd0;
   // A software CTRL write overrides the one-shot EN clear in the same cycle
   assign w_ctrl_nxt = w_wr_ctrl ? (PrBE[0] ? PrWD[3:0] : r_ctrl) :
                       w_clr_en  ? {r_ctrl[3:1], 1'b0} : r_ctrl;

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_clr_en = 1'b0;
      w_set_pend = 1'b0;
      case (r_state)
         S_IDLE: w_state_nxt = w_en ? S_LOAD : S_IDLE;
         S_LOAD: begin
            w_count_nxt = r_preset;
            w_state_nxt = S_CNT;
         end
         S_CNT: begin
            if (!w_en) w_state_nxt = S_IDLE;
            else if (r_count <= 32'd1) begin
               w_count_nxt = 32'd0;
               w_state_nxt = S_INT;
            end else w_count_nxt = r_count - 32'd1;
         end
         S_INT: begin
            w_set_pend = 1'b1;
            w_clr_en = !w_reload;
            w_state_nxt = w_reload ? S_LOAD : S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else r_state <= w_state_nxt;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_ctrl <= '0;
         r_preset <= '0;
         r_count <= '0;
         r_pend <= 1'b0;
         PrRD <= '0;
         hit_q <= 1'b0;
      end else begin
         r_ctrl <= w_ctrl_nxt;
         r_preset <= w_wr_pre ? be_merge(r_preset, PrWD, PrBE) : r_preset;
         r_count <= w_count_nxt;
         r_pend <= w_set_pend | (r_pend & ~w_wr_ctrl);
         PrRD <= w_hit ? w_rd : 32'd0;
         hit_q <= w_hit;
      end
endmodule
